// File: rtl/bq_pkg.sv
// Shared types, default sizes and helpers for the biquad output decimator.
// The top's parameters default to these values; the FIFO uses clog2 for pointer widths.
package bq_pkg;

  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_OUTWIDTH  = 8;
  localparam int DEF_MAXSHIFT  = 7;
  localparam int DEF_FIFODEPTH = 4;

  // A 2^MAXSHIFT-sample sum of DATAWIDTH-bit values cannot overflow this width.
  localparam int ACCW = DEF_DATAWIDTH + DEF_MAXSHIFT;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bq_sync_fifo.sv
// Small first-word-fall-through FIFO: the head entry is presented as soon as it is stored.
// A full FIFO accepts a push only when a pop happens in the same cycle.
module bq_sync_fifo
  import bq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    clear,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and level do, and head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH by itself.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bq_out_decim.sv
// Decimates the biquad output by 2^k with a rounded boxcar average and queues the
// top byte of each average in a FWFT FIFO toward the consumer.
module bq_out_decim
  import bq_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int OUTWIDTH  = DEF_OUTWIDTH,
  parameter int MAXSHIFT  = DEF_MAXSHIFT,
  parameter int FIFODEPTH = DEF_FIFODEPTH
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic [DATAWIDTH-1:0]        y_i,
  input  logic                        y_valid_i,
  input  logic [2:0]                  dec_shift_i,
  input  logic                        clear_i,
  output logic [OUTWIDTH-1:0]         out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [clog2(FIFODEPTH):0]   fifo_level_o,
  output logic                        overflow_o
);

  localparam int ACC_W = DATAWIDTH + MAXSHIFT;
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = MAXSHIFT + 1;

  state_t                    state;
  logic [2:0]                k_lat;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          count;

  logic [2:0]                k_in;
  logic [2:0]                k_use;
  logic signed [DATAWIDTH-1:0] y_s;
  logic signed [SUM_W-1:0]   acc_term;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   rnd;
  logic signed [SUM_W-1:0]   avg_full;
  logic [DATAWIDTH-1:0]      avg;
  logic                      in_range;
  logic [CNT_W-1:0]          target;
  logic                      last;
  logic                      push;
  logic [OUTWIDTH-1:0]       push_data;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign y_s = y_i;

  generate
    if (MAXSHIFT >= 7) begin : g_k_nosat
      assign k_in = dec_shift_i;
    end else begin : g_k_sat
      assign k_in = (dec_shift_i > 3'(MAXSHIFT)) ? 3'(MAXSHIFT) : dec_shift_i;
    end
  endgenerate

  // The window-completing sample is folded in combinationally so its average is
  // pushed on the same edge that samples it.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned.
  always_comb begin
    k_use    = (state == IDLE) ? k_in : k_lat;
    target   = CNT_W'(1) << k_lat;
    last     = (state == ACCUM) ? ((count + 1'b1) == target) : (k_in == 3'd0);
    acc_term = (state == ACCUM) ? SUM_W'(acc) : '0;
    sum      = SUM_W'(y_s) + acc_term;
    rnd      = (k_use == 3'd0) ? '0 : (SUM_W'(1) << (k_use - 3'd1));
    avg_full = (sum + rnd) >>> k_use;
    in_range = (&avg_full[SUM_W-1:DATAWIDTH-1]) || !(|avg_full[SUM_W-1:DATAWIDTH-1]);
    avg      = in_range ? avg_full[DATAWIDTH-1:0]
                        : {avg_full[SUM_W-1], {(DATAWIDTH-1){~avg_full[SUM_W-1]}}};
    push_data = avg[DATAWIDTH-1 -: OUTWIDTH];
    push      = y_valid_i && last && !clear_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      k_lat <= '0;
      acc   <= '0;
      count <= '0;
    end else if (clear_i) begin
      state <= IDLE;
      k_lat <= '0;
      acc   <= '0;
      count <= '0;
    end else if (y_valid_i) begin
      case (state)
        IDLE: begin
          // k = 0 emits straight from IDLE without opening a window.
          if (k_in != 3'd0) begin
            k_lat <= k_in;
            acc   <= ACC_W'(y_s);
            count <= CNT_W'(1);
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (last) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
          end else begin
            acc   <= acc + ACC_W'(y_s);
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_o <= 1'b1;
    end
  end

  bq_sync_fifo #(
    .WIDTH (OUTWIDTH),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (clear_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (out_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

endmodule
